// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream/decrypt stage: FSM states, ASCII bounds and
// the printable-character predicate used for early wrong-key rejection.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_I,
    ST_WAIT_I,
    ST_LATCH_I,
    ST_WAIT_J,
    ST_LATCH_J,
    ST_WRITE_I,
    ST_WRITE_J,
    ST_WAIT_F,
    ST_LATCH_F,
    ST_NEXT,
    ST_DONE
  } prga_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A_LO  = 8'h61;
  localparam logic [7:0] ASCII_Z_LO  = 8'h7A;
  localparam int         RC4_MSG_LEN = 32;

  // Plaintext alphabet is space plus lowercase letters only.
  function automatic logic is_printable(input logic [7:0] b);
    return (b == ASCII_SPACE) || ((b >= ASCII_A_LO) && (b <= ASCII_Z_LO));
  endfunction

endpackage

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA: swaps S[i]/S[j] in the S RAM, forms f = S[S[i]+S[j]] and writes ROM[k]^f
// to the output RAM, one byte every ten cycles, optionally aborting on a non-printable byte.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN     = RC4_MSG_LEN,
  parameter bit CHECK_ASCII = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       finish,
  output logic       key_invalid,
  output logic [7:0] s_addr,
  output logic [7:0] s_wdata,
  output logic       s_wren,
  input  logic [7:0] s_rdata,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_rdata,
  output logic [7:0] out_addr,
  output logic [7:0] out_wdata,
  output logic       out_wren
);

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  prga_state_t state_q, state_d;
  logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d, si_q, si_d, sj_q, sj_d;
  logic [7:0]  s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [7:0]  rom_addr_q, rom_addr_d, out_addr_q, out_addr_d, out_wdata_q, out_wdata_d;
  logic        s_wren_q, s_wren_d, out_wren_q, out_wren_d, key_invalid_q, key_invalid_d;

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    si_d          = si_q;
    sj_d          = sj_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_wren_d      = s_wren_q;
    rom_addr_d    = rom_addr_q;
    out_addr_d    = out_addr_q;
    out_wdata_d   = out_wdata_q;
    out_wren_d    = out_wren_q;
    key_invalid_d = key_invalid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d           = 8'd0;
          j_d           = 8'd0;
          k_d           = 8'd0;
          key_invalid_d = 1'b0;
          state_d       = ST_SET_I;
        end
      end
      ST_SET_I: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        state_d  = ST_WAIT_I;
      end
      ST_WAIT_I: state_d = ST_LATCH_I;
      ST_LATCH_I: begin
        si_d     = s_rdata;
        j_d      = j_q + s_rdata;
        s_addr_d = j_q + s_rdata;
        state_d  = ST_WAIT_J;
      end
      ST_WAIT_J: state_d = ST_LATCH_J;
      // Swap is two back-to-back writes; i==j simply writes the same value twice.
      ST_LATCH_J: begin
        sj_d      = s_rdata;
        s_addr_d  = i_q;
        s_wdata_d = s_rdata;
        s_wren_d  = 1'b1;
        state_d   = ST_WRITE_I;
      end
      ST_WRITE_I: begin
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
        state_d   = ST_WRITE_J;
      end
      ST_WRITE_J: begin
        s_wren_d   = 1'b0;
        s_addr_d   = si_q + sj_q;
        rom_addr_d = k_q;
        state_d    = ST_WAIT_F;
      end
      ST_WAIT_F: state_d = ST_LATCH_F;
      ST_LATCH_F: begin
        out_addr_d  = k_q;
        out_wdata_d = s_rdata ^ rom_rdata;
        out_wren_d  = 1'b1;
        state_d     = ST_NEXT;
      end
      ST_NEXT: begin
        out_wren_d = 1'b0;
        k_d        = k_q + 8'd1;
        if (CHECK_ASCII && !is_printable(out_wdata_q)) begin
          key_invalid_d = 1'b1;
          state_d       = ST_DONE;
        end else if (k_q == LAST_K) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SET_I;
        end
      end
      // Holding start high here must not retrigger a run.
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      i_q           <= 8'd0;
      j_q           <= 8'd0;
      k_q           <= 8'd0;
      si_q          <= 8'd0;
      sj_q          <= 8'd0;
      s_addr_q      <= 8'd0;
      s_wdata_q     <= 8'd0;
      s_wren_q      <= 1'b0;
      rom_addr_q    <= 8'd0;
      out_addr_q    <= 8'd0;
      out_wdata_q   <= 8'd0;
      out_wren_q    <= 1'b0;
      key_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      si_q          <= si_d;
      sj_q          <= sj_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_wren_q      <= s_wren_d;
      rom_addr_q    <= rom_addr_d;
      out_addr_q    <= out_addr_d;
      out_wdata_q   <= out_wdata_d;
      out_wren_q    <= out_wren_d;
      key_invalid_q <= key_invalid_d;
    end
  end

  assign finish      = (state_q == ST_DONE);
  assign key_invalid = key_invalid_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wren      = s_wren_q;
  assign rom_addr    = rom_addr_q;
  assign out_addr    = out_addr_q;
  assign out_wdata   = out_wdata_q;
  assign out_wren    = out_wren_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: synchronous RAM/ROM models around the DUT and a plain RC4
// reference (KSA + PRGA on arrays) predicting every output write, abort point and final S.
module tb_rc4_prga_decrypt;

  localparam int ML = 32;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       finish, key_invalid;
  logic [7:0] s_addr, s_wdata, s_rdata, rom_addr, rom_rdata, out_addr, out_wdata;
  logic       s_wren, out_wren;

  rc4_prga_decrypt #(.MSG_LEN(ML), .CHECK_ASCII(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .key_invalid(key_invalid),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_wren(out_wren)
  );

  always #5 clk = ~clk;

  // Memories: registered address, q valid after the sampling edge.
  logic [7:0] s_ram [256];
  logic [7:0] stage [256];
  logic [7:0] rom   [256];
  logic [7:0] out_ram [256];
  logic       load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int n = 0; n < 256; n++) s_ram[n] <= stage[n];
    end else if (s_wren) begin
      s_ram[s_addr] <= s_wdata;
    end
    s_rdata   <= s_ram[s_addr];
    rom_rdata <= rom[rom_addr];
    if (out_wren) out_ram[out_addr] <= out_wdata;
  end

  // Reference state
  logic [7:0]  m_s [256];
  logic [7:0]  m_out [256];
  int          m_nb;
  bit          m_abort;
  logic [7:0]  key [8];
  int          klen;
  logic [15:0] exp_q [$];

  int n_tests = 0, n_fail = 0;
  int swr = 0, owr = 0, last_cyc = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit tb_printable(input logic [7:0] b);
    return b == 8'h20 || (b >= 8'h61 && b <= 8'h7a);
  endfunction

  // One clock; observe outputs on the falling edge and check every output write.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    @(negedge clk);
    if (s_wren) swr++;
    if (out_wren) begin
      owr++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got addr %0h data %0h, expected no write", out_addr, out_wdata);
      end else begin
        e = exp_q.pop_front();
        check("out_write", {out_addr, out_wdata}, e);
      end
    end
  endtask

  task automatic identity_s();
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
  endtask

  task automatic ksa();
    logic [7:0] j, t;
    identity_s();
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + m_s[n] + key[n % klen];
      t = m_s[n]; m_s[n] = m_s[j]; m_s[j] = t;
    end
  endtask

  task automatic random_key();
    klen = $urandom_range(3, 8);
    for (int n = 0; n < 8; n++) key[n] = 8'($urandom);
    ksa();
  endtask

  // Textbook RC4 PRGA on m_s; XORs against rom and stops after a bad byte when chk is set.
  task automatic model(input int len, input bit chk);
    logic [7:0] i, j, t, o;
    i = 0; j = 0; m_nb = 0; m_abort = 0;
    for (int k = 0; k < len; k++) begin
      i = i + 1;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      o = rom[k] ^ m_s[8'(m_s[i] + m_s[j])];
      m_out[k] = o;
      m_nb = k + 1;
      if (chk && !tb_printable(o)) begin
        m_abort = 1;
        break;
      end
    end
  endtask

  // Build a ROM whose plaintext is printable except at abort_at (negative: none).
  task automatic gen_rom(input int abort_at);
    logic [7:0] sv [256];
    logic [7:0] pt;
    int r;
    sv = m_s;
    for (int n = 0; n < 256; n++) rom[n] = 8'h00;
    model(ML, 1'b0);
    m_s = sv;
    for (int k = 0; k < ML; k++) begin
      r = $urandom_range(0, 26);
      pt = (r == 0) ? 8'h20 : 8'(8'h60 + r);
      if (k == abort_at) pt = 8'($urandom_range(1, 31));
      rom[k] = pt ^ m_out[k];
    end
  endtask

  task automatic prep_and_start();
    stage = m_s;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    model(ML, 1'b1);
    for (int k = 0; k < m_nb; k++) exp_q.push_back({8'(k), m_out[k]});
    start = 1'b1;
    tick();
    check("ki_cleared_on_start", key_invalid, 1'b0);
  endtask

  task automatic do_run();
    int cyc, s0, o0, bad;
    s0 = swr; o0 = owr;
    prep_and_start();
    cyc = 0;
    while (!finish && cyc < 4000) begin
      tick();
      cyc++;
    end
    last_cyc = cyc;
    check("finish_seen", finish, 1'b1);
    check("run_cycles", cyc, 10 * m_nb);
    check("key_invalid", key_invalid, m_abort);
    check("pending_writes", exp_q.size(), 0);
    check("out_wren_count", owr - o0, m_nb);
    check("s_wren_count", swr - s0, 2 * m_nb);
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_ram[n] !== m_s[n]) bad++;
    check("final_s_ram", bad, 0);
    bad = 0;
    for (int k = 0; k < m_nb; k++) if (out_ram[k] !== m_out[k]) bad++;
    check("out_ram", bad, 0);
  endtask

  task automatic end_run();
    start = 1'b0;
    tick();
    check("finish_low_after_start_drop", finish, 1'b0);
  endtask

  initial begin
    int s0, o0;
    bit hold_ok;
    reset = 1'b1; start = 1'b0; load_req = 1'b0;
    for (int n = 0; n < 256; n++) begin rom[n] = 8'h00; stage[n] = 8'(n); end
    repeat (3) tick();
    check("reset_outputs",
          {finish, key_invalid, s_wren, out_wren, s_addr, s_wdata, rom_addr, out_addr, out_wdata},
          0);
    reset = 1'b0;
    tick();

    // Hand-computed pins on the reference model itself.
    identity_s();
    model(4, 1'b0);
    check("pin_identity_out", {m_out[0], m_out[1], m_out[2], m_out[3]}, 32'h0205070D);
    check("pin_identity_s", {m_s[2], m_s[3], m_s[4], m_s[5], m_s[9]}, 40'h0305090204);
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79; klen = 3;
    ksa();
    {rom[0], rom[1], rom[2], rom[3], rom[4], rom[5], rom[6], rom[7], rom[8]} =
      72'hBBF316E8D940AF0AD3;
    model(9, 1'b0);
    check("pin_key_plaintext",
          {m_out[0], m_out[1], m_out[2], m_out[3], m_out[4], m_out[5], m_out[6], m_out[7], m_out[8]},
          72'h506C61696E74657874);

    // Identity S, ROM[0]=00: byte 0 decrypts to 02 and aborts.
    identity_s();
    for (int n = 0; n < 256; n++) rom[n] = 8'h00;
    do_run();
    check("abort0_cycles", last_cyc, 10);
    check("abort0_byte", {out_ram[0], key_invalid}, {8'h02, 1'b1});
    end_run();

    // Identity S, ROM[0]=63 -> 'a', full valid message.
    identity_s();
    gen_rom(-1);
    rom[0] = 8'h63;
    do_run();
    check("valid_byte0", {out_ram[0], key_invalid}, {8'h61, 1'b0});
    check("valid_cycles", last_cyc, 320);
    end_run();

    // Randomized keys, mixing full runs and aborts at random bytes.
    for (int r = 0; r < 6; r++) begin
      random_key();
      gen_rom((r % 2 == 1) ? int'($urandom_range(0, ML - 1)) : -1);
      do_run();
      end_run();
    end

    // start held high past finish: no restart, no writes.
    random_key();
    gen_rom(5);
    do_run();
    s0 = swr; o0 = owr; hold_ok = 1'b1;
    repeat (20) begin
      tick();
      if (!finish) hold_ok = 1'b0;
    end
    check("hold_finish_high", hold_ok, 1'b1);
    check("hold_no_writes", (swr - s0) + (owr - o0), 0);
    end_run();
    random_key();
    gen_rom(-1);
    do_run();
    end_run();

    // Reset in the middle of a run.
    random_key();
    gen_rom(-1);
    prep_and_start();
    repeat (56) tick();
    reset = 1'b1;
    tick();
    check("midreset_state", {finish, s_wren, out_wren}, 3'b000);
    reset = 1'b0;
    start = 1'b0;
    exp_q.delete();
    tick();
    check("midreset_idle", {finish, s_wren, out_wren}, 3'b000);
    random_key();
    gen_rom(-1);
    do_run();
    end_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
